vanilla_core_pc_hist_counters: RTL and testbench
================================================

Name: vanilla_core_pc_hist_counters

Overview:
- Synthesizable, on-chip successor to the DPI-based per-PC stall/instruction histogram.
- Bins each retired-cycle event by PC range and event category into saturating hardware counters.
- Counters are readable through a valid/ready port, so profiling works in silicon and emulation, not only simulation.
- Sits beside a vanilla core. Its event input comes from the core's stall-cause classifier: one category per cycle.

Parameters:
- pc_width_p, 32: event PC width.
- els_p, 64: number of in-range PC bins; bin index els_p is the out-of-range bin.
- num_cat_p, 8: number of event categories.
- ctr_width_p, 32: width of each counter.
- bin_shift_p, 2: log2 bytes per bin; default 2 means 1 instruction per bin.
- bin_w_lp, `BSG_SAFE_CLOG2(els_p+1)`: bin address width (derived).
- cat_w_lp, `BSG_SAFE_CLOG2(num_cat_p)`: category address width (derived).

Ports:
- clk_i, in, 1: clock.
- reset_n_i, in, 1: reset, synchronous and active-low.
- en_i, in, 1: count enable; 0 freezes all counters.
- clear_i, in, 1: pulse that starts a full counter clear.
- base_pc_i, in, pc_width_p: base PC of bin 0; quasi-static.
- ev_v_i, in, 1: event valid for this cycle.
- ev_pc_i, in, pc_width_p: PC to attribute the event to.
- ev_cat_i, in, cat_w_lp: event category.
- rd_v_i, in, 1: read request.
- rd_ready_o, out, 1: read request accepted.
- rd_bin_i, in, bin_w_lp: bin to read.
- rd_cat_i, in, cat_w_lp: category to read.
- rd_v_o, out, 1: read data valid.
- rd_data_o, out, ctr_width_p: counter value.
- rd_sat_o, out, 1: counter has saturated.
- busy_o, out, 1: clear in progress.
- dropped_o, out, ctr_width_p: saturating count of discarded events.

Behaviour:
- Reset: synchronous, active-low; reset_n_i=0 sampled at posedge.
  - FSM enters CLEAR with index 0, so busy_o=1 and rd_ready_o=0 after reset.
  - rd_v_o=0, rd_data_o=0, rd_sat_o=0, dropped_o=0.
  - Counter array contents are don't-care until the clear walk finishes.
- Storage: (els_p+1)*num_cat_p counters, each with a sticky sat bit. Implementable as flops or a 1R1W array.

FSM states:
- IDLE: on clear_i=1, go to CLEAR with idx=0.
- CLEAR:
  - Each cycle, zero the counters and sat bits of all categories of bin idx, then idx++.
  - After bin els_p, go to IDLE.
  - Takes exactly els_p+1 cycles; busy_o=1 throughout.
  - clear_i during CLEAR restarts idx at 0.
  - reset_n_i=0 mid-clear also restarts at idx 0.

Bin mapping:
- off = ev_pc_i - base_pc_i, computed in pc_width_p bits.
- If ev_pc_i < base_pc_i (unsigned) or (off >> bin_shift_p) >= els_p, then bin = els_p.
- Otherwise bin = off >> bin_shift_p.

Increment:
- Condition: ev_v_i & en_i & IDLE & ev_cat_i < num_cat_p.
- At the posedge, counter[bin][cat] += 1; the update is visible the next cycle.
- Saturation: at all-ones the counter holds and its sat bit is set.
- One event per cycle, so there is no multi-write conflict.

Dropped events:
- Cases: ev_v_i & en_i while in CLEAR, or ev_v_i & en_i with ev_cat_i >= num_cat_p.
- Each increments dropped_o, saturating at all-ones.
- dropped_o is cleared only by reset, not by clear_i.
- ev_v_i with en_i=0 is ignored silently.

Read:
- rd_ready_o = IDLE.
- Handshake rd_v_i & rd_ready_o at cycle t gives rd_v_o=1 at t+1 for exactly one cycle.
- rd_data_o/rd_sat_o hold the value at the start of cycle t, before any same-cycle increment to the same counter. Read-before-write; no bypass.
- rd_bin_i > els_p returns rd_data_o=0 and rd_sat_o=0, still with rd_v_o=1.
- Back-to-back reads are accepted every cycle; throughput is 1 per cycle.
- rd_data_o holds its last value while rd_v_o=0.

Simultaneous events:
- clear_i and an event in the same IDLE cycle: the increment is performed, then the clear walk zeroes it.
- clear_i and a read in the same IDLE cycle: the read is accepted and returns the pre-clear value.

Test Plan:
1. Release reset with base_pc_i=0x1000 and els_p=64, then wait.
   -> busy_o=1 for 65 cycles, then 0; rd_ready_o rises with it; reading bin 5, cat 3 returns 0.
2. ev_pc_i=0x1010, cat 2, 3 consecutive cycles with en_i=1.
   -> bin 4, cat 2 reads 3; bin 4, cat 1 reads 0.
3. ev_pc_i=0x0FFC, then 0x1100, then 0x10FC, all cat 0.
   -> out-of-range bin 64, cat 0 reads 2; bin 63, cat 0 reads 1.
4. ctr_width_p=4; 17 events to bin 0, cat 0.
   -> counter reads 15 with rd_sat_o=1.
   -> then issue clear_i, wait for busy_o to fall: counter reads 0 with rd_sat_o=0.
5. Counter at 7, read plus increment of the same counter in the same cycle.
   -> rd_data_o=7 next cycle; a following read returns 8.
6. Events during CLEAR: 2; event with ev_cat_i=num_cat_p: 1; events with en_i=0: 5.
   -> dropped_o=3; no counter changes.

Source files
------------

// File: rtl/vanilla_core_pc_hist_counters_if.sv
// Event and counter-read channels of the PC histogram block.
// The core/profiler side is master; the histogram is slave.
interface vanilla_core_pc_hist_counters_if #(
  parameter int pc_width_p  = 32,
  parameter int els_p       = 64,
  parameter int num_cat_p   = 8,
  parameter int ctr_width_p = 32
);
  localparam int bin_w_lp = (els_p + 1 > 1) ? $clog2(els_p + 1) : 1;
  localparam int cat_w_lp = (num_cat_p > 1) ? $clog2(num_cat_p) : 1;

  logic                   ev_v_i;
  logic [pc_width_p-1:0]  ev_pc_i;
  logic [cat_w_lp-1:0]    ev_cat_i;

  logic                   rd_v_i;
  logic                   rd_ready_o;
  logic [bin_w_lp-1:0]    rd_bin_i;
  logic [cat_w_lp-1:0]    rd_cat_i;
  logic                   rd_v_o;
  logic [ctr_width_p-1:0] rd_data_o;
  logic                   rd_sat_o;

  modport master (
    output ev_v_i, ev_pc_i, ev_cat_i, rd_v_i, rd_bin_i, rd_cat_i,
    input  rd_ready_o, rd_v_o, rd_data_o, rd_sat_o
  );

  modport slave (
    input  ev_v_i, ev_pc_i, ev_cat_i, rd_v_i, rd_bin_i, rd_cat_i,
    output rd_ready_o, rd_v_o, rd_data_o, rd_sat_o
  );
endinterface

// File: rtl/vanilla_core_pc_hist_counters.sv
// Per-PC-bin, per-category saturating event counters with a valid/ready read port
// and a bin-at-a-time clear walk.
module vanilla_core_pc_hist_counters #(
  parameter int pc_width_p  = 32,
  parameter int els_p       = 64,
  parameter int num_cat_p   = 8,
  parameter int ctr_width_p = 32,
  parameter int bin_shift_p = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   en_i,
  input  logic                   clear_i,
  input  logic [pc_width_p-1:0]  base_pc_i,
  vanilla_core_pc_hist_counters_if.slave bus,
  output logic                   busy_o,
  output logic [ctr_width_p-1:0] dropped_o
);
  localparam int bin_w_lp = (els_p + 1 > 1) ? $clog2(els_p + 1) : 1;
  localparam int cat_w_lp = (num_cat_p > 1) ? $clog2(num_cat_p) : 1;
  localparam logic [pc_width_p-1:0] els_pc_lp   = pc_width_p'(els_p);
  localparam logic [bin_w_lp-1:0]   last_bin_lp = bin_w_lp'(els_p);
  localparam logic [cat_w_lp:0]     num_cat_lp  = (cat_w_lp + 1)'(num_cat_p);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e                 state_q, state_d;
  logic [bin_w_lp-1:0]    idx_q, idx_d;
  logic [ctr_width_p-1:0] ctr_q [els_p+1][num_cat_p];
  logic [ctr_width_p-1:0] ctr_d [els_p+1][num_cat_p];
  logic                   sat_q [els_p+1][num_cat_p];
  logic                   sat_d [els_p+1][num_cat_p];
  logic                   rd_v_q, rd_v_d;
  logic [ctr_width_p-1:0] rd_data_q, rd_data_d;
  logic                   rd_sat_q, rd_sat_d;
  logic [ctr_width_p-1:0] dropped_q, dropped_d;

  logic [pc_width_p-1:0]  off, off_shift;
  logic [bin_w_lp-1:0]    ev_bin;
  logic                   is_idle, ev_fire, ev_cat_ok, rd_cat_ok, rd_fire;

  // Out-of-range bin catches PCs below the base as well as past the last bin.
  always_comb begin
    off       = bus.ev_pc_i - base_pc_i;
    off_shift = off >> bin_shift_p;
    ev_bin    = ((bus.ev_pc_i < base_pc_i) || (off_shift >= els_pc_lp))
                ? last_bin_lp : off_shift[bin_w_lp-1:0];
    is_idle   = (state_q == ST_IDLE);
    ev_fire   = bus.ev_v_i && en_i;
    ev_cat_ok = ({1'b0, bus.ev_cat_i} < num_cat_lp);
    rd_cat_ok = ({1'b0, bus.rd_cat_i} < num_cat_lp);
    rd_fire   = bus.rd_v_i && is_idle;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ctr_d     = ctr_q;
    sat_d     = sat_q;
    rd_v_d    = rd_fire;
    rd_data_d = rd_data_q;
    rd_sat_d  = rd_sat_q;
    dropped_d = dropped_q;

    // Read samples the array before this cycle's increment lands.
    if (rd_fire) begin
      if ((bus.rd_bin_i <= last_bin_lp) && rd_cat_ok) begin
        rd_data_d = ctr_q[bus.rd_bin_i][bus.rd_cat_i];
        rd_sat_d  = sat_q[bus.rd_bin_i][bus.rd_cat_i];
      end else begin
        rd_data_d = '0;
        rd_sat_d  = 1'b0;
      end
    end

    if (ev_fire) begin
      if (is_idle && ev_cat_ok) begin
        if (ctr_q[ev_bin][bus.ev_cat_i] == '1) begin
          sat_d[ev_bin][bus.ev_cat_i] = 1'b1;
        end else begin
          ctr_d[ev_bin][bus.ev_cat_i] = ctr_q[ev_bin][bus.ev_cat_i] + ctr_width_p'(1);
        end
      end else if (dropped_q != '1) begin
        dropped_d = dropped_q + ctr_width_p'(1);
      end
    end

    // Clear walk only runs while no increments are accepted, so it never collides with one.
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        for (int c = 0; c < num_cat_p; c++) begin
          ctr_d[idx_q][c] = '0;
          sat_d[idx_q][c] = 1'b0;
        end
        if (clear_i) begin
          idx_d = '0;
        end else if (idx_q == last_bin_lp) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + bin_w_lp'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter contents are left alone in reset; the clear walk that follows zeroes them.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_CLEAR;
      idx_q     <= '0;
      rd_v_q    <= 1'b0;
      rd_data_q <= '0;
      rd_sat_q  <= 1'b0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ctr_q     <= ctr_d;
      sat_q     <= sat_d;
      rd_v_q    <= rd_v_d;
      rd_data_q <= rd_data_d;
      rd_sat_q  <= rd_sat_d;
      dropped_q <= dropped_d;
    end
  end

  assign bus.rd_ready_o = is_idle;
  assign bus.rd_v_o     = rd_v_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_sat_o   = rd_sat_q;
  assign busy_o         = (state_q == ST_CLEAR);
  assign dropped_o      = dropped_q;
endmodule

// File: tb/tb_vanilla_core_pc_hist_counters.sv
// Directed bench for the PC histogram: stimulus pushes expected read results into a
// scoreboard queue, and a negedge monitor pops and compares each returned read.
module tb_vanilla_core_pc_hist_counters;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        en_i;
  logic        clear_i;
  logic [31:0] base_pc;
  logic        busy;
  logic [3:0]  dropped;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [3:0] data;
    logic       sat;
    string      name;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  always #5 clk = ~clk;

  vanilla_core_pc_hist_counters_if #(
    .pc_width_p(32), .els_p(64), .num_cat_p(6), .ctr_width_p(4)
  ) bus ();

  vanilla_core_pc_hist_counters #(
    .pc_width_p(32), .els_p(64), .num_cat_p(6), .ctr_width_p(4), .bin_shift_p(2)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .en_i      (en_i),
    .clear_i   (clear_i),
    .base_pc_i (base_pc),
    .bus       (bus),
    .busy_o    (busy),
    .dropped_o (dropped)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Every cycle the DUT presents read data, it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.rd_v_o) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_read: got rd_v_o=1, required no pending read");
      end else begin
        monE = expQ.pop_front();
        checkOutput({monE.name, "_data"}, int'(bus.rd_data_o), int'(monE.data));
        checkOutput({monE.name, "_sat"}, int'(bus.rd_sat_o), int'(monE.sat));
      end
    end
  end

  task automatic applyStimulus(input logic ev_v, input logic [31:0] pc, input logic [2:0] cat,
                               input logic en, input logic rd_v, input logic [6:0] rbin,
                               input logic [2:0] rcat, input logic clr);
    bus.ev_v_i   = ev_v;
    bus.ev_pc_i  = pc;
    bus.ev_cat_i = cat;
    en_i         = en;
    bus.rd_v_i   = rd_v;
    bus.rd_bin_i = rbin;
    bus.rd_cat_i = rcat;
    clear_i      = clr;
    @(posedge clk);
    #1;
    bus.ev_v_i = 1'b0;
    bus.rd_v_i = 1'b0;
    clear_i    = 1'b0;
    en_i       = 1'b1;
  endtask

  task automatic sendEvent(input logic [31:0] pc, input logic [2:0] cat, input logic en);
    applyStimulus(1'b1, pc, cat, en, 1'b0, 7'd0, 3'd0, 1'b0);
  endtask

  task automatic issueRead(input logic [6:0] rbin, input logic [2:0] rcat,
                           input logic [3:0] data, input logic sat, input string name);
    exp_t e;
    e.data = data;
    e.sat  = sat;
    e.name = name;
    expQ.push_back(e);
    applyStimulus(1'b0, 32'd0, 3'd0, 1'b1, 1'b1, rbin, rcat, 1'b0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, 7'd0, 3'd0, 1'b0);
  endtask

  // Counts remaining busy cycles at negedges, bounded so a stuck clear still ends the run.
  task automatic waitBusyFall(input int expCycles, input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n >= 300) break;
      n++;
    end
    checkOutput(name, n, expCycles);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t pending;
    reset_n      = 1'b0;
    en_i         = 1'b1;
    clear_i      = 1'b0;
    base_pc      = 32'h1000;
    bus.ev_v_i   = 1'b0;
    bus.ev_pc_i  = '0;
    bus.ev_cat_i = '0;
    bus.rd_v_i   = 1'b0;
    bus.rd_bin_i = '0;
    bus.rd_cat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(busy), 1);
    checkOutput("reset_ready", int'(bus.rd_ready_o), 0);
    checkOutput("reset_rd_v", int'(bus.rd_v_o), 0);
    checkOutput("reset_rd_data", int'(bus.rd_data_o), 0);
    checkOutput("reset_rd_sat", int'(bus.rd_sat_o), 0);
    checkOutput("reset_dropped", int'(dropped), 0);
    reset_n = 1'b1;
    waitBusyFall(65, "reset_clear_len");
    checkOutput("ready_after_clear", int'(bus.rd_ready_o), 1);
    issueRead(7'd5, 3'd3, 4'd0, 1'b0, "init_b5c3");

    // In-range binning: 0x1010 lands in bin 4.
    repeat (3) sendEvent(32'h1010, 3'd2, 1'b1);
    issueRead(7'd4, 3'd2, 4'd3, 1'b0, "b4c2");
    issueRead(7'd4, 3'd1, 4'd0, 1'b0, "b4c1");

    // Below base and past the end both go to bin 64; 0x10FC is the last in-range bin.
    sendEvent(32'h0FFC, 3'd0, 1'b1);
    sendEvent(32'h1100, 3'd0, 1'b1);
    sendEvent(32'h10FC, 3'd0, 1'b1);
    issueRead(7'd64, 3'd0, 4'd2, 1'b0, "b64c0");
    issueRead(7'd63, 3'd0, 4'd1, 1'b0, "b63c0");
    issueRead(7'd65, 3'd0, 4'd0, 1'b0, "bin65");
    issueRead(7'd127, 3'd0, 4'd0, 1'b0, "bin127");

    // Saturation of a 4-bit counter, then a restarted clear.
    repeat (17) sendEvent(32'h1000, 3'd0, 1'b1);
    issueRead(7'd0, 3'd0, 4'd15, 1'b1, "sat_b0c0");
    idleCycles(1);
    checkOutput("hold_rd_v", int'(bus.rd_v_o), 0);
    checkOutput("hold_rd_data", int'(bus.rd_data_o), 15);
    applyStimulus(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, 7'd0, 3'd0, 1'b1);
    checkOutput("clear_ready_low", int'(bus.rd_ready_o), 0);
    idleCycles(3);
    applyStimulus(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, 7'd0, 3'd0, 1'b1);
    waitBusyFall(65, "restart_clear_len");
    issueRead(7'd0, 3'd0, 4'd0, 1'b0, "cleared_b0c0");
    issueRead(7'd4, 3'd2, 4'd0, 1'b0, "cleared_b4c2");

    // Read and increment of the same counter in one cycle returns the old value.
    repeat (7) sendEvent(32'h1004, 3'd1, 1'b1);
    pending.data = 4'd7;
    pending.sat  = 1'b0;
    pending.name = "rbw_b1c1";
    expQ.push_back(pending);
    applyStimulus(1'b1, 32'h1004, 3'd1, 1'b1, 1'b1, 7'd1, 3'd1, 1'b0);
    issueRead(7'd1, 3'd1, 4'd8, 1'b0, "after_rbw_b1c1");

    // Clear together with an event and a read, then drops in CLEAR, bad category and en=0.
    pending.data = 4'd8;
    pending.sat  = 1'b0;
    pending.name = "clr_same_read";
    expQ.push_back(pending);
    applyStimulus(1'b1, 32'h100C, 3'd0, 1'b1, 1'b1, 7'd1, 3'd1, 1'b1);
    sendEvent(32'h1008, 3'd0, 1'b1);
    sendEvent(32'h1008, 3'd0, 1'b1);
    waitBusyFall(63, "clear_remaining_len");
    checkOutput("dropped_in_clear", int'(dropped), 2);
    sendEvent(32'h1008, 3'd6, 1'b1);
    repeat (5) sendEvent(32'h1008, 3'd0, 1'b0);
    checkOutput("dropped_total", int'(dropped), 3);
    issueRead(7'd2, 3'd0, 4'd0, 1'b0, "no_count_b2c0");
    issueRead(7'd3, 3'd0, 4'd0, 1'b0, "clr_event_b3c0");
    issueRead(7'd1, 3'd1, 4'd0, 1'b0, "clr_b1c1");
    repeat (15) sendEvent(32'h1008, 3'd7, 1'b1);
    checkOutput("dropped_sat", int'(dropped), 15);

    idleCycles(3);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
